// File: rtl/ib_counter_pkg.sv
// Shared definitions for the ib counter family: counting-mode encodings.
// Combinational only; no latency, no backpressure.
package ib_counter_pkg;

   typedef enum logic [1:0] {
      MODE_UP_WRAP = 2'b00,
      MODE_DN_WRAP = 2'b01,
      MODE_UP_SAT  = 2'b10,
      MODE_BOUNCE  = 2'b11
   } mode_e;

endpackage : ib_counter_pkg

// File: rtl/ib_prescaler.sv
// Enable-gated prescaler: one tick per i_div+1 enabled cycles, restartable by i_clr.
// Tick is combinational from the registered count; no backpressure.
module ib_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [PRE_W-1:0] i_div,
   output logic             o_tick
);

   localparam logic [PRE_W-1:0] P_ONE = {{(PRE_W-1){1'b0}}, 1'b1};

   logic [PRE_W-1:0] p_q, p_d;

   // A lowered i_div can leave p above it; p then runs on and wraps naturally.
   assign o_tick = i_en && (p_q == i_div);

   always_comb begin
      p_d = p_q;
      if (i_clr) begin
         p_d = '0;
      end else if (i_en) begin
         p_d = o_tick ? '0 : p_q + P_ONE;
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

endmodule : ib_prescaler

// File: rtl/ib_counter_gen.sv
// Parametrised counter: up-wrap, down-wrap, up-saturate and bounce modes with prescaler.
// Outputs registered, update on the edge ending a tick/clr/load cycle; no backpressure.
module ib_counter_gen #(
   parameter int WIDTH = 16,
   parameter int PRE_W = 4
) (
   input  logic             i_clk,
   input  logic             i_nrst,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_load_val,
   input  logic [WIDTH-1:0] i_limit,
   input  logic [1:0]       i_mode,
   input  logic [PRE_W-1:0] i_div,
   output logic [WIDTH-1:0] o_c,
   output logic             o_tc,
   output logic             o_dir,
   output logic             o_sat
);

   import ib_counter_pkg::*;

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_e            mode;
   logic             tick;
   logic [WIDTH-1:0] c_q, c_d;
   logic             tc_q, tc_d;
   logic             sat_q, sat_d;
   logic             dir_q, dir_d;

   logic [WIDTH-1:0] c_inc, c_dec, lim_dec, load_clamped;
   logic             c_ge_lim, c_is_zero, lim_is_zero, inc_hits_lim;

   assign mode = mode_e'(i_mode);

   // Load and clear both restart the prescaler so the next tick is a full period away.
   ib_prescaler #(
      .PRE_W (PRE_W)
   ) u_prescaler (
      .i_clk  (i_clk),
      .i_nrst (i_nrst),
      .i_en   (i_en),
      .i_clr  (i_clr | i_load),
      .i_div  (i_div),
      .o_tick (tick)
   );

   assign c_inc        = c_q + ONE;
   assign c_dec        = c_q - ONE;
   assign lim_dec      = i_limit - ONE;
   assign c_ge_lim     = (c_q >= i_limit);
   assign c_is_zero    = (c_q == '0);
   assign lim_is_zero  = (i_limit == '0);
   assign inc_hits_lim = (c_inc == i_limit);
   assign load_clamped = (i_load_val < i_limit) ? i_load_val : i_limit;

   always_comb begin
      c_d   = c_q;
      tc_d  = 1'b0;
      dir_d = dir_q;
      sat_d = (mode == MODE_UP_SAT) ? sat_q : 1'b0;

      if (i_clr) begin
         c_d   = '0;
         dir_d = 1'b0;
         sat_d = 1'b0;
      end else if (i_load) begin
         c_d   = load_clamped;
         sat_d = 1'b0;
      end else if (tick) begin
         case (mode)
            MODE_UP_WRAP: begin
               if (c_ge_lim) begin
                  c_d  = '0;
                  tc_d = 1'b1;
               end else begin
                  c_d = c_inc;
               end
            end
            // Counts down even from above a freshly lowered limit.
            MODE_DN_WRAP: begin
               if (c_is_zero) begin
                  c_d  = i_limit;
                  tc_d = 1'b1;
               end else begin
                  c_d = c_dec;
               end
            end
            MODE_UP_SAT: begin
               if (!c_ge_lim) begin
                  c_d = c_inc;
                  if (inc_hits_lim) begin
                     tc_d  = 1'b1;
                     sat_d = 1'b1;
                  end
               end else begin
                  c_d   = i_limit;
                  sat_d = 1'b1;
               end
            end
            MODE_BOUNCE: begin
               if (lim_is_zero) begin
                  c_d   = '0;
                  dir_d = ~dir_q;
                  tc_d  = 1'b1;
               end else if (!dir_q && c_ge_lim) begin
                  c_d   = lim_dec;
                  dir_d = 1'b1;
                  tc_d  = 1'b1;
               end else if (dir_q && c_is_zero) begin
                  c_d   = ONE;
                  dir_d = 1'b0;
                  tc_d  = 1'b1;
               end else begin
                  c_d = dir_q ? c_dec : c_inc;
               end
            end
            default: begin
               c_d = c_q;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         c_q   <= '0;
         tc_q  <= 1'b0;
         sat_q <= 1'b0;
         dir_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         tc_q  <= tc_d;
         sat_q <= sat_d;
         dir_q <= dir_d;
      end
   end

   always_comb begin
      case (mode)
         MODE_DN_WRAP: o_dir = 1'b1;
         MODE_BOUNCE:  o_dir = dir_q;
         default:      o_dir = 1'b0;
      endcase
   end

   assign o_c   = c_q;
   assign o_tc  = tc_q;
   assign o_sat = sat_q;

endmodule : ib_counter_gen
